// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(INST_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-side and decoder-side signals of the fetch queue, bundled as one interface.
interface fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of fetched {pc, inst} entries with push, pop and synchronous flush.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != FULL_COUNT) || do_pop);
  assign head_entry = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_entry;
        tail      <= tail + 1'b1;
      end
      if (do_pop) begin
        head <= head + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding memory request, DEPTH-entry queue, redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to the decoder when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head_entry;
  fetch_entry_t  resp_entry;
  logic          issue;
  logic          resp_ok;
  logic          bypass_take;
  logic          fifo_push;
  logic          fifo_pop;

  // Requesting only below full guarantees room for the single outstanding response.
  assign bus.mem_req  = !rst && (state == IDLE) && (count < FULL_COUNT) && !bus.redirect;
  assign bus.mem_addr = fetch_pc;
  assign issue        = bus.mem_req && bus.mem_gnt;
  assign resp_ok      = (state == WAIT) && bus.mem_rvalid && !bus.redirect;
  assign resp_entry   = '{pc: req_pc, inst: bus.mem_rdata};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_active;
  assign bypass_active  = resp_ok && (count == '0);
  assign bypass_take    = bypass_active && bus.inst_ready;
  assign bus.inst_valid = (count != '0) || bypass_active;
  assign bus.inst       = bypass_active ? bus.mem_rdata : head_entry.inst;
  assign bus.inst_pc    = bypass_active ? req_pc : head_entry.pc;
`else
  assign bypass_take    = 1'b0;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = head_entry.inst;
  assign bus.inst_pc    = head_entry.pc;
`endif

  assign fifo_push = resp_ok && !bypass_take;
  assign fifo_pop  = (count != '0) && bus.inst_ready && !bus.redirect;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (bus.redirect),
    .push_entry(resp_entry),
    .head_entry(head_entry),
    .count     (count)
  );

  // A redirect always wins the next fetch address; an outstanding request is drained, not reused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= word_align(RESET_PC);
      req_pc   <= '0;
    end else begin
      if (bus.redirect) begin
        fetch_pc <= word_align(bus.redirect_pc);
      end else if (issue) begin
        fetch_pc <= fetch_pc + INST_BYTES;
      end
      if (issue) begin
        req_pc <= fetch_pc;
      end
      case (state)
        IDLE: begin
          if (issue) begin
            state <= bus.redirect ? DRAIN : WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state <= IDLE;
          end else if (bus.redirect) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory model records issues, expected entries are queued on response.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  fetch_queue_if bus();

  fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int           check_count = 0;
  int           error_count = 0;
  logic         gnt;
  logic         rdy;
  logic         redir;
  logic [31:0]  redir_pc;
  int           resp_delay;
  int           pend_cnt;
  logic [31:0]  pend_addr;
  logic         pend_drop;
  fetch_entry_t exp_q[$];
  logic [31:0]  issue_log[$];
  logic [31:0]  pop_log[$];
  logic         last_req;
  logic [31:0]  last_addr;
  logic         last_valid;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One clock: drive inputs and the memory response at negedge, then score the outputs.
  task automatic applyStimulus();
    logic         rv;
    logic         kept;
    logic         pushed;
    fetch_entry_t resp;
    @(negedge clk);
    rv = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      rv = (pend_cnt == 0);
    end
    resp.pc        = pend_addr;
    resp.inst      = inst_of(pend_addr);
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rv ? resp.inst : 32'h0;
    bus.mem_gnt    = gnt;
    bus.inst_ready = rdy;
    bus.redirect   = redir;
    bus.redirect_pc = redir_pc;
    #1;
    kept   = rv && !pend_drop && !redir;
    pushed = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (kept && exp_q.size() == 0) begin
      exp_q.push_back(resp);
      pushed = 1'b1;
    end
`endif
    checkOutput("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
    if (bus.inst_valid && exp_q.size() != 0) begin
      checkOutput("inst_pc", bus.inst_pc, exp_q[0].pc);
      checkOutput("inst", bus.inst, exp_q[0].inst);
      if (rdy && !redir) begin
        pop_log.push_back(bus.inst_pc);
        void'(exp_q.pop_front());
      end
    end
    if (redir) begin
      exp_q.delete();
      pend_drop = pend_drop | (pend_cnt > 0);
    end
    if (rv) begin
      if (kept && !pushed) exp_q.push_back(resp);
      pend_drop = 1'b0;
    end
    last_req   = bus.mem_req;
    last_addr  = bus.mem_addr;
    last_valid = bus.inst_valid;
    if (bus.mem_req && gnt) begin
      checkOutput("one_outstanding", 32'(pend_cnt != 0 || rv), 32'd0);
      issue_log.push_back(bus.mem_addr);
      pend_cnt  = resp_delay;
      pend_addr = bus.mem_addr;
      pend_drop = redir;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    gnt = 1'b0; rdy = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.inst_ready = 1'b0;
    pend_cnt = 0; pend_drop = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("rst_inst", bus.inst, 32'h0);
    checkOutput("rst_inst_pc", bus.inst_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("first_req", 32'(bus.mem_req), 32'd1);
    checkOutput("first_addr", bus.mem_addr, 32'h0);
  endtask

  task automatic flushTo(input logic [31:0] pc);
    gnt = 1'b0;
    repeat (4) applyStimulus();
    redir = 1'b1;
    redir_pc = pc;
    applyStimulus();
    redir = 1'b0;
  endtask

  task automatic runUntilIssues(input int n, input int budget, input string tag);
    int start;
    int cyc;
    start = issue_log.size();
    cyc = 0;
    while (issue_log.size() < start + n && cyc < budget) begin
      applyStimulus();
      cyc++;
    end
    checkOutput(tag, 32'(issue_log.size() >= start + n), 32'd1);
  endtask

  task automatic runUntilPops(input int n, input int budget, input string tag);
    int start;
    int cyc;
    start = pop_log.size();
    cyc = 0;
    while (pop_log.size() < start + n && cyc < budget) begin
      applyStimulus();
      cyc++;
    end
    checkOutput(tag, 32'(pop_log.size() >= start + n), 32'd1);
  endtask

  initial begin
    int ibase;
    int pbase;
    int cyc;
    rst = 1'b1;
    resp_delay = 1;
    pend_cnt = 0;
    pend_addr = 32'h0;
    pend_drop = 1'b0;
    doReset();

    // In-order fetch of 0, 4, 8 with a one-cycle memory
    gnt = 1'b1; rdy = 1'b1;
    runUntilIssues(3, 20, "t037_issue_timeout");
    repeat (3) applyStimulus();
    checkOutput("t037_iss0", qat(issue_log, 0), 32'h0);
    checkOutput("t037_iss1", qat(issue_log, 1), 32'h4);
    checkOutput("t037_iss2", qat(issue_log, 2), 32'h8);
    checkOutput("t037_pop0", qat(pop_log, 0), 32'h0);
    checkOutput("t037_pop1", qat(pop_log, 1), 32'h4);
    checkOutput("t037_pop2", qat(pop_log, 2), 32'h8);

    // Stalled consumer fills the queue, one pop reopens fetch
    flushTo(32'h100);
    gnt = 1'b1; rdy = 1'b0;
    ibase = issue_log.size();
    repeat (12) applyStimulus();
    checkOutput("t038_issues", 32'(issue_log.size() - ibase), 32'd4);
    checkOutput("t038_full_noreq", 32'(last_req), 32'd0);
    rdy = 1'b1;
    applyStimulus();
    checkOutput("t038_pop_cycle_noreq", 32'(last_req), 32'd0);
    rdy = 1'b0;
    applyStimulus();
    checkOutput("t038_reopen_req", 32'(last_req), 32'd1);
    checkOutput("t038_reopen_addr", last_addr, 32'h110);

    // Grant withheld for three cycles
    flushTo(32'h10);
    checkOutput("t039_redir_noreq", 32'(last_req), 32'd0);
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t039_hold_req", 32'(last_req), 32'd1);
      checkOutput("t039_hold_addr", last_addr, 32'h10);
    end
    ibase = issue_log.size();
    gnt = 1'b1;
    applyStimulus();
    checkOutput("t039_issued", 32'(issue_log.size() - ibase), 32'd1);
    checkOutput("t039_issue_addr", qat(issue_log, issue_log.size() - 1), 32'h10);

    // Redirect while waiting on the response for 0x8
    resp_delay = 3;
    flushTo(32'h0);
    gnt = 1'b1; rdy = 1'b1;
    cyc = 0;
    while (qat(issue_log, issue_log.size() - 1) !== 32'h8 && cyc < 40) begin
      applyStimulus();
      cyc++;
    end
    checkOutput("t040_reach8", qat(issue_log, issue_log.size() - 1), 32'h8);
    pbase = pop_log.size();
    redir = 1'b1; redir_pc = 32'h200;
    applyStimulus();
    redir = 1'b0;
    applyStimulus();
    checkOutput("t040_drain_noreq", 32'(last_req), 32'd0);
    checkOutput("t040_valid", 32'(last_valid), 32'd0);
    runUntilIssues(1, 20, "t040_issue_timeout");
    checkOutput("t040_next_addr", qat(issue_log, issue_log.size() - 1), 32'h200);
    runUntilPops(1, 20, "t040_pop_timeout");
    checkOutput("t040_next_pc", qat(pop_log, pbase), 32'h200);

    // Redirect coinciding with pop and response, three entries queued
    resp_delay = 1;
    flushTo(32'h0);
    gnt = 1'b1; rdy = 1'b0;
    runUntilIssues(4, 30, "t041_issue_timeout");
    pbase = pop_log.size();
    redir = 1'b1; redir_pc = 32'h303; rdy = 1'b1;
    applyStimulus();
    redir = 1'b0;
    applyStimulus();
    checkOutput("t041_valid", 32'(last_valid), 32'd0);
    checkOutput("t041_req", 32'(last_req), 32'd1);
    checkOutput("t041_addr", last_addr, 32'h300);
    runUntilPops(1, 20, "t041_pop_timeout");
    checkOutput("t041_next_pc", qat(pop_log, pbase), 32'h300);

    // Address wrap at the top of memory
    flushTo(32'hFFFF_FFFF);
    gnt = 1'b1; rdy = 1'b1;
    pbase = pop_log.size();
    applyStimulus();
    checkOutput("t042_top_addr", last_addr, 32'hFFFF_FFFC);
    runUntilIssues(1, 10, "t042_issue_timeout");
    checkOutput("t042_wrap_addr", qat(issue_log, issue_log.size() - 1), 32'h0);
    runUntilPops(2, 20, "t042_pop_timeout");
    checkOutput("t042_pop_top", qat(pop_log, pbase), 32'hFFFF_FFFC);
    checkOutput("t042_pop_wrap", qat(pop_log, pbase + 1), 32'h0);

    // Reset in the middle of an outstanding request
    resp_delay = 3;
    applyStimulus();
    applyStimulus();
    doReset();
    applyStimulus();
    checkOutput("t032_valid", 32'(last_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries buffered; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_req  output  1  instruction-memory fetch request.
REQ-006 mem_addr  output  32  word-aligned fetch address; valid while mem_req=1.
REQ-007 mem_gnt  input  1  memory accepted request this cycle (mem_req&mem_gnt = issue).
REQ-008 mem_rvalid  input  1  fetch response valid; arrives at least 1 cycle after issue.
REQ-009 mem_rdata  input  32  fetched instruction word.
REQ-010 redirect  input  1  branch/jump taken by core; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-012 inst_valid  output  1  queue head holds an instruction for the decoder.
REQ-013 inst  output  32  head instruction word.
REQ-014 inst_pc  output  32  address of head instruction.
REQ-015 inst_ready  input  1  core consumes head this cycle (inst_valid&inst_ready = pop).

Function
REQ-016 FSM states: IDLE (no request outstanding), WAIT (one outstanding, response wanted), DRAIN (one outstanding, response discarded); at most one request outstanding.
REQ-017 IDLE: mem_req=1 iff count<DEPTH and redirect=0; mem_addr=fetch_pc.
REQ-018 Issue in IDLE: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32 wrap), go WAIT.
REQ-019 mem_req, mem_addr held stable until mem_gnt, except when redirect changes them.
REQ-020 WAIT, mem_rvalid=1, redirect=0: push {req_pc, mem_rdata} at tail, go IDLE; next request may issue same cycle as IDLE is entered only from the following cycle (one bubble).
REQ-021 Queue push-to-inst_valid latency 1 cycle (registered), absent bypass (REQ-034).
REQ-022 Pop advances head; simultaneous push and pop keeps count unchanged, valid at any count.
REQ-023 Space always exists for a WAIT response: issue only when count<DEPTH, pops never add entries.
REQ-024 Redirect (highest priority): queue flushed (count<=0, inst_valid=0 next cycle), fetch_pc<=redirect_pc, any pop or push that cycle ignored.
REQ-025 Redirect in IDLE without issue: stay IDLE, request next cycle at redirect_pc.
REQ-026 Redirect in IDLE coinciding with issue (mem_gnt=1): go DRAIN (stale address accepted); fetch_pc<=redirect_pc.
REQ-027 Redirect in WAIT, mem_rvalid=0: go DRAIN; mem_rvalid=1: discard response, go IDLE.
REQ-028 DRAIN: mem_req=0; mem_rvalid discarded, go IDLE; further redirect only updates fetch_pc.
REQ-029 mem_rvalid in IDLE ignored (protocol error, no state change).
REQ-030 redirect_pc[1:0] ignored; fetch addresses forced word-aligned.

Reset
REQ-031 rst asserted: state=IDLE, fetch_pc=RESET_PC, count=0, head=tail=0, mem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-032 Reset mid-transaction abandons outstanding request; a response arriving after release is ignored (IDLE rule).
REQ-033 First mem_req=1 in first cycle after rst deasserts, mem_addr=RESET_PC.

Configuration
REQ-034 Macro FETCH_QUEUE_BYPASS_EN: defined -> when queue empty and WAIT response arrives without redirect, inst_valid/inst/inst_pc driven combinationally from mem_rdata/req_pc same cycle; popped without storing if inst_ready=1, else stored. Undefined -> no combinational path from mem_* to inst_*; latency per REQ-021.

Structure
REQ-035 Shared package holds fetch state enum (IDLE, WAIT, DRAIN), fetch entry struct {pc[31:0], inst[31:0]}, constant INST_BYTES=4.
REQ-036 One sub-module fetch_fifo (DEPTH-entry circular buffer, push/pop/flush, count) instantiated inside fetch_queue.

Verification
REQ-037 Reset release, RESET_PC=0, mem_gnt=1, rvalid 1 cycle later -> addresses 0,4,8 issued; inst_pc 0,4,8 in order.
REQ-038 inst_ready=0, DEPTH=4 -> exactly 4 issues, then mem_req=0; one pop -> mem_req=1 next cycle.
REQ-039 mem_gnt low 3 cycles -> mem_addr stable at 0x10 throughout; issue on 4th cycle.
REQ-040 Redirect to 0x200 while WAIT for 0x8 -> DRAIN, 0x8 data discarded, inst_valid=0, next issue 0x200, next inst_pc=0x200.
REQ-041 Redirect same cycle as pop and rvalid with 3 entries -> count=0, nothing pushed, next mem_addr=redirect_pc.
REQ-042 fetch_pc=0xFFFF_FFFC issued -> next mem_addr=0x0; with BYPASS_EN, empty queue + rvalid + inst_ready -> inst_valid=1 that cycle.
